// File: rtl/immediate_encoder_if.sv
// Immediate format type plus the bundled handshake/data interface of the
// immediate encoder (input beat, output beat and error-counter control).
package immediate_encoder_pkg;
   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } immediate_e;
endpackage

interface immediate_encoder_if #(
   parameter int COUNT_WIDTH = 16
);
   import immediate_encoder_pkg::*;

   logic                   valid_i;
   logic                   ready_o;
   logic [31:0]            instruction_i;
   immediate_e             type_i;
   logic [31:0]            immediate_i;
   logic                   valid_o;
   logic                   ready_i;
   logic [31:0]            instruction_o;
   logic                   range_error_o;
   logic [COUNT_WIDTH-1:0] error_count_o;
   logic                   clear_count_i;

   modport master (
      output valid_i, instruction_i, type_i, immediate_i, ready_i, clear_count_i,
      input  ready_o, valid_o, instruction_o, range_error_o, error_count_o
   );

   modport slave (
      input  valid_i, instruction_i, type_i, immediate_i, ready_i, clear_count_i,
      output ready_o, valid_o, instruction_o, range_error_o, error_count_o
   );
endinterface

// File: rtl/immediate_encoder.sv
// Two-stage valid/ready pipeline that scatters an immediate value into the
// RISC-V I/S/B/U/J immediate fields of an instruction and flags range errors.
module immediate_encoder #(
   parameter int COUNT_WIDTH = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   immediate_encoder_if.slave bus
);
   import immediate_encoder_pkg::*;

   logic [31:0]            imm;
   logic [31:0]            enc_word;
   logic                   enc_err;

   logic                   s1_valid;
   logic [31:0]            s1_word;
   logic                   s1_err;
   logic                   s2_valid;
   logic [31:0]            s2_word;
   logic                   s2_err;
   logic                   s1_load;
   logic                   s2_load;
   logic [COUNT_WIDTH-1:0] count_reg;

   assign imm = bus.immediate_i;

   // Field sign-extension checks: the bits above the top encoded bit must all
   // replicate it, otherwise the value does not survive decode.
   always_comb begin
      enc_word = bus.instruction_i;
      enc_err  = 1'b0;
      case (bus.type_i)
         IMM_S: begin
            enc_word[31:25] = imm[11:5];
            enc_word[11:7]  = imm[4:0];
            enc_err         = !(&imm[31:11] || ~|imm[31:11]);
         end
         IMM_B: begin
            enc_word[31]    = imm[12];
            enc_word[30:25] = imm[10:5];
            enc_word[11:8]  = imm[4:1];
            enc_word[7]     = imm[11];
            enc_err         = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
         end
         IMM_U: begin
            enc_word[31:12] = imm[31:12];
            enc_err         = |imm[11:0];
         end
         IMM_J: begin
            enc_word[31]    = imm[20];
            enc_word[30:21] = imm[10:1];
            enc_word[20]    = imm[11];
            enc_word[19:12] = imm[19:12];
            enc_err         = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
         end
         default: begin
            enc_word[31:20] = imm[11:0];
            enc_err         = !(&imm[31:11] || ~|imm[31:11]);
         end
      endcase
   end

   assign s2_load = !s2_valid || bus.ready_i;
   assign s1_load = !s1_valid || s2_load;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
         s1_err   <= 1'b0;
         s2_valid <= 1'b0;
         s2_word  <= '0;
         s2_err   <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= bus.valid_i;
            if (bus.valid_i) begin
               s1_word <= enc_word;
               s1_err  <= enc_err;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_word <= s1_word;
               s2_err  <= s1_err;
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_reg <= '0;
      end else if (bus.clear_count_i) begin
         count_reg <= '0;
      end else if (s2_valid && bus.ready_i && s2_err && !(&count_reg)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign bus.ready_o       = s1_load;
   assign bus.valid_o       = s2_valid;
   assign bus.instruction_o = s2_word;
   assign bus.range_error_o = s2_err;
   assign bus.error_count_o = count_reg;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench: arithmetic reference encoder/decoder, in-order
// scoreboard and occupancy model checked every cycle, plus directed cases.
`timescale 1ns/1ps
module tb_immediate_encoder;
   import immediate_encoder_pkg::*;

   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   accepted = 0;
   int   model_count = 0;
   logic expect_valid = 1'b0;

   typedef struct {
      logic [31:0] word;
      logic        err;
      int          fmt;
      logic [31:0] imm;
   } beat_t;
   beat_t exp_q[$];

   immediate_encoder_if #(.COUNT_WIDTH(CW)) bus ();
   immediate_encoder #(.COUNT_WIDTH(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int eff_fmt(logic [2:0] t);
      return (t > 3'd4) ? 0 : int'(t);
   endfunction

   function automatic logic [31:0] ref_encode(logic [31:0] ins, int f, logic [31:0] imm);
      logic [31:0] mask;
      logic [31:0] field;
      case (f)
         1: begin
            mask  = 32'hFE000F80;
            field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
         end
         2: begin
            mask  = 32'hFE000F80;
            field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
         end
         3: begin
            mask  = 32'hFFFFF000;
            field = imm & 32'hFFFFF000;
         end
         4: begin
            mask  = 32'hFFFFF000;
            field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
         end
         default: begin
            mask  = 32'hFFF00000;
            field = (imm & 32'hFFF) << 20;
         end
      endcase
      return (ins & ~mask) | field;
   endfunction

   function automatic logic ref_err(int f, logic [31:0] imm);
      longint s;
      s = $signed(imm);
      case (f)
         2:       return (s < -4096) || (s > 4095) || imm[0];
         3:       return (imm % 4096) != 0;
         4:       return (s < -(64'sd1 << 20)) || (s >= (64'sd1 << 20)) || imm[0];
         default: return (s < -2048) || (s > 2047);
      endcase
   endfunction

   // Immediate generator (decode direction), used for the round-trip property.
   function automatic logic [31:0] ref_decode(logic [31:0] w, int f);
      int top;
      int hi;
      top = w[31] ? -1 : 0;
      case (f)
         1: begin
            hi = $signed(w) >>> 25;
            return hi * 32 + int'(w[11:7]);
         end
         2:       return top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
         3:       return w & 32'hFFFFF000;
         4:       return top * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
         default: return $signed(w) >>> 20;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Per-cycle compare against the scoreboard and occupancy model.
   always @(negedge clk) begin
      beat_t b;
      logic  out_err;
      if (rst) begin
         exp_q.delete();
         model_count  = 0;
         expect_valid = 1'b0;
      end else begin
         out_err = 1'b0;
         check("ready_o", 32'(bus.ready_o), 32'((exp_q.size() < 2) || bus.ready_i));
         check("error_count_o", 32'(bus.error_count_o), 32'(model_count));
         check("valid_o", 32'(bus.valid_o), 32'(expect_valid));
         if (bus.valid_o && exp_q.size() > 0) begin
            b = exp_q[0];
            check("instruction_o", bus.instruction_o, b.word);
            check("range_error_o", 32'(bus.range_error_o), 32'(b.err));
            if (!b.err)
               check("round_trip", ref_decode(bus.instruction_o, b.fmt), b.imm);
            if (bus.ready_i) begin
               out_err = b.err;
               void'(exp_q.pop_front());
            end
         end
         if (bus.clear_count_i)
            model_count = 0;
         else if (out_err && model_count < (1 << CW) - 1)
            model_count++;
         expect_valid = exp_q.size() > 0;
         if (bus.valid_i && bus.ready_o) begin
            b.fmt  = eff_fmt(bus.type_i);
            b.imm  = bus.immediate_i;
            b.word = ref_encode(bus.instruction_i, b.fmt, bus.immediate_i);
            b.err  = ref_err(b.fmt, bus.immediate_i);
            exp_q.push_back(b);
            accepted++;
         end
      end
   end

   task automatic set_beat(logic [31:0] ins, logic [2:0] t, logic [31:0] imm);
      bus.valid_i       = 1'b1;
      bus.instruction_i = ins;
      bus.type_i        = immediate_e'(t);
      bus.immediate_i   = imm;
   endtask

   // Returns at posedge+1 of the accepting edge with valid_i dropped.
   task automatic send(logic [31:0] ins, logic [2:0] t, logic [31:0] imm);
      set_beat(ins, t, imm);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.ready_o) begin
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
            return;
         end
      end
      check("send_timeout", 32'd1, 32'd0);
      bus.valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !bus.valid_o) return;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] imm;
      logic [2:0]  t;
      int          f;

      bus.valid_i       = 1'b0;
      bus.instruction_i = '0;
      bus.type_i        = IMM_I;
      bus.immediate_i   = '0;
      bus.ready_i       = 1'b1;
      bus.clear_count_i = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("rst_instruction_o", bus.instruction_o, 32'd0);
      check("rst_range_error_o", 32'(bus.range_error_o), 32'd0);
      check("rst_error_count_o", 32'(bus.error_count_o), 32'd0);
      check("rst_ready_o", 32'(bus.ready_o), 32'd1);
      rst = 1'b0;

      // Hand-computed expectations pinning the reference model.
      check("model_I", ref_encode(32'h13, 0, 32'hFFFFF800), 32'h80000013);
      check("model_I_err", 32'(ref_err(0, 32'h800)), 32'd1);
      check("model_B", ref_encode(32'h63, 2, 32'hFFE), 32'h7E000FE3);
      check("model_B_err", 32'(ref_err(2, 32'h3)), 32'd1);
      check("model_U", ref_encode(32'h37, 3, 32'h12345000), 32'h12345037);
      check("model_J", ref_encode(32'h6F, 4, 32'hFFF00000), 32'h8000006F);
      check("model_S", ref_encode(32'h23, 1, 32'hFFFFFFFF), 32'hFE000FA3);
      check("model_J_dec", ref_decode(32'h8000006F, 4), 32'hFFF00000);

      // I-type latency: accepted at edge N, visible after edge N+1.
      @(posedge clk);
      #1;
      send(32'h13, 3'd0, 32'hFFFFF800);
      check("lat_edgeN_valid_o", 32'(bus.valid_o), 32'd0);
      @(posedge clk);
      #1;
      check("lat_edgeN1_valid_o", 32'(bus.valid_o), 32'd1);
      check("lat_edgeN1_instruction_o", bus.instruction_o, 32'h80000013);
      drain();
      send(32'h13, 3'd0, 32'h00000800);
      drain();
      check("I_err_count", 32'(bus.error_count_o), 32'd1);

      send(32'h63, 3'd2, 32'h00000FFE);
      send(32'h63, 3'd2, 32'h00000003);
      send(32'h37, 3'd3, 32'h12345000);
      send(32'h37, 3'd3, 32'h12345001);
      send(32'h6F, 3'd4, 32'hFFF00000);
      send(32'hFFFFF06F, 3'd4, 32'h0);
      send(32'hFFFFFFB7, 3'd3, 32'h0);
      send(32'hFFFFFFFF, 3'd1, 32'h5);
      send(32'h00000013, 3'd7, 32'h7FF);
      drain();

      // Saturation at 3 with a 2-bit counter.
      @(posedge clk);
      #1;
      bus.clear_count_i = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_count_i = 1'b0;
      for (int i = 0; i < 5; i++) send(32'h13, 3'd0, 32'h1000 + i);
      drain();
      check("count_saturated", 32'(bus.error_count_o), 32'd3);

      // Clear coinciding with an errored output handshake.
      send(32'h13, 3'd0, 32'h800);
      @(posedge clk);
      #1;
      check("clr_valid_o", 32'(bus.valid_o), 32'd1);
      bus.clear_count_i = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_count_i = 1'b0;
      check("clr_count", 32'(bus.error_count_o), 32'd0);

      // Backpressure: A, B fill both stages, C waits.
      bus.ready_i = 1'b0;
      set_beat(32'hAAAA0013, 3'd0, 32'h1);
      @(posedge clk);
      #1;
      set_beat(32'hBBBB0013, 3'd0, 32'h2);
      @(posedge clk);
      #1;
      check("bp_ready_o_full", 32'(bus.ready_o), 32'd0);
      set_beat(32'hCCCC0013, 3'd0, 32'h12345);
      repeat (3) @(posedge clk);
      #1;
      check("bp_ready_o_held", 32'(bus.ready_o), 32'd0);
      check("bp_instruction_o", bus.instruction_o, 32'h001A0013);
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      drain();
      check("bp_count", 32'(bus.error_count_o), 32'd1);

      // Asynchronous reset with both stages full.
      bus.ready_i = 1'b0;
      set_beat(32'h13, 3'd0, 32'h10);
      @(posedge clk);
      #1;
      set_beat(32'h13, 3'd0, 32'h20);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      check("pre_rst_valid_o", 32'(bus.valid_o), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("async_rst_count", 32'(bus.error_count_o), 32'd0);
      check("async_rst_ready_o", 32'(bus.ready_o), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.ready_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_valid_o", 32'(bus.valid_o), 32'd0);

      // Random traffic with random backpressure and occasional clears.
      accepted = 0;
      for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
         @(posedge clk);
         #1;
         r = $urandom;
         t = 3'($urandom_range(0, 7));
         f = eff_fmt(t);
         case (f)
            2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
            3:       imm = {r[31:12], 12'h000};
            4:       imm = {{11{r[20]}}, r[20:1], 1'b0};
            default: imm = {{20{r[11]}}, r[11:0]};
         endcase
         if ($urandom_range(0, 9) == 0) imm = $urandom;
         set_beat($urandom, t, imm);
         bus.valid_i       = ($urandom_range(0, 9) < 7);
         bus.ready_i       = ($urandom_range(0, 9) < 6);
         bus.clear_count_i = ($urandom_range(0, 49) == 0);
      end
      bus.valid_i       = 1'b0;
      bus.ready_i       = 1'b1;
      bus.clear_count_i = 1'b0;
      check("rand_beats_accepted", 32'(accepted >= 10000), 32'd1);
      drain();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
